// File: rtl/deframer_pkg.sv
// Shared types and constants for the serial deframer.
// PARITY_EN adds one even-parity bit to every frame.
package deframer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } collect_state_t;

    localparam int DATA_W_DEFAULT = 8;

`ifdef PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int FRAME_LEN_DEFAULT = DATA_W_DEFAULT + PARITY_BITS;

    function automatic int frame_len(input int data_w);
        return data_w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/deframer_outbuf.sv
// One-entry valid/ready holding register for completed words.
// A completion that finds the entry occupied and not draining is dropped and flagged sticky.
module deframer_outbuf
    import deframer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Clr,
    input  logic              Load,
    input  logic [DATA_W-1:0] LoadWord,
    input  logic              LoadPerr,
    input  logic              Ready,
    output logic [DATA_W-1:0] Dout,
    output logic              Valid,
    output logic              ParityErr,
    output logic              Overrun
);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Dout      <= '0;
            Valid     <= 1'b0;
            ParityErr <= 1'b0;
            Overrun   <= 1'b0;
        end else if (Clr) begin
            // Dout is deliberately left alone on a flush
            Valid   <= 1'b0;
            Overrun <= 1'b0;
        end else if (Load) begin
            if (!Valid || Ready) begin
                Dout      <= LoadWord;
                ParityErr <= LoadPerr;
                Valid     <= 1'b1;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (Valid && Ready) begin
            Valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_deframer.sv
// Serial-in, parallel-out receiver: LSB-first bit collection into a one-entry output buffer.
// Define PARITY_EN to append an even-parity bit to each frame and make ParityErr live.
//
// state   | meaning
// COLLECT | shifting in data bits, BitCnt counts them
// PARITY  | all data bits held, next sampled bit is the parity bit
module serial_deframer
    import deframer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                        Clk,
    input  logic                        nReset,
    input  logic                        Clr,
    input  logic                        ShiftEn,
    input  logic                        Sin,
    input  logic                        Ready,
    output logic [DATA_W-1:0]           Dout,
    output logic                        Valid,
    output logic                        ParityErr,
    output logic                        Overrun,
    output logic [$clog2(DATA_W+2)-1:0] BitCnt
);

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam int FRAME_LEN = frame_len(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic              sample;
    logic              complete;
    logic [DATA_W-1:0] word;
    logic              word_perr;

    assign sample = ShiftEn & ~Clr;

`ifdef PARITY_EN
    collect_state_t    state;
    collect_state_t    state_nxt;
    logic [DATA_W-1:0] shreg;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state   <= COLLECT;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (Clr) begin
                shreg <= '0;
            end else if (sample && state == COLLECT) begin
                shreg <= {Sin, shreg[DATA_W-1:1]};
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        complete    = 1'b0;
        word        = shreg;
        word_perr   = ^{shreg, Sin};
        if (Clr) begin
            state_nxt   = COLLECT;
            bit_cnt_nxt = '0;
        end else if (ShiftEn) begin
            case (state)
                COLLECT: begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT - CNT_W'(1)) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    complete    = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = COLLECT;
                end
                default: state_nxt = COLLECT;
            endcase
        end
    end
`else
    // Only DATA_W-1 bits are stored; the final bit joins straight from Sin on completion.
    logic [DATA_W-2:0] shreg;

    assign word      = {Sin, shreg};
    assign word_perr = 1'b0;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            bit_cnt <= bit_cnt_nxt;
            if (Clr) begin
                shreg <= '0;
            end else if (sample) begin
                shreg <= word[DATA_W-1:1];
            end
        end
    end

    always_comb begin
        bit_cnt_nxt = bit_cnt;
        complete    = 1'b0;
        if (Clr) begin
            bit_cnt_nxt = '0;
        end else if (ShiftEn) begin
            if (bit_cnt == LAST_BIT) begin
                complete    = 1'b1;
                bit_cnt_nxt = '0;
            end else begin
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
        end
    end
`endif

    assign BitCnt = bit_cnt;

    deframer_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .Clk       (Clk),
        .nReset    (nReset),
        .Clr       (Clr),
        .Load      (complete),
        .LoadWord  (word),
        .LoadPerr  (word_perr),
        .Ready     (Ready),
        .Dout      (Dout),
        .Valid     (Valid),
        .ParityErr (ParityErr),
        .Overrun   (Overrun)
    );

endmodule

// File: tb/tb_serial_deframer.sv
// Scoreboard bench for serial_deframer: directed scenarios then randomized traffic.
// Define PARITY_EN for both bench and RTL to exercise the parity build.
module tb_serial_deframer;

    localparam int DATA_W = 8;
`ifdef PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    localparam int CNT_W = $clog2(DATA_W + 2);

    logic              Clk = 1'b0;
    logic              nReset;
    logic              Clr;
    logic              ShiftEn;
    logic              Sin;
    logic              Ready;
    logic [DATA_W-1:0] Dout;
    logic              Valid;
    logic              ParityErr;
    logic              Overrun;
    logic [CNT_W-1:0]  BitCnt;

    serial_deframer #(.DATA_W(DATA_W)) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .Clr       (Clr),
        .ShiftEn   (ShiftEn),
        .Sin       (Sin),
        .Ready     (Ready),
        .Dout      (Dout),
        .Valid     (Valid),
        .ParityErr (ParityErr),
        .Overrun   (Overrun),
        .BitCnt    (BitCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [DATA_W-1:0] w;
        logic              p;
    } item_t;

    // Reference model: buffered words, bits of the current frame, buffer/overrun state
    item_t             exp_q[$];
    bit                bits_q[$];
    bit                buf_full;
    bit                ovr_exp;
    logic [DATA_W-1:0] dout_exp;
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (nReset === 1'b1 && Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got Dout=%0h with Valid, expected no word", Dout);
            end else begin
                check("sb_dout", Dout, exp_q[0].w);
                check("sb_perr", ParityErr, exp_q[0].p);
                if (Ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        bits_q.delete();
        exp_q.delete();
        buf_full = 0;
        ovr_exp  = 0;
        dout_exp = '0;
    endtask

    task automatic model_edge(input bit se, input bit s, input bit rdy, input bit clr);
        bit                accept;
        bit                done;
        logic [DATA_W-1:0] w;
        logic              p;
        accept = buf_full && rdy;
        done   = 0;
        w      = '0;
        p      = 1'b0;
        if (clr) begin
            bits_q.delete();
            exp_q.delete();
            buf_full = 0;
            ovr_exp  = 0;
        end else begin
            if (se) begin
                bits_q.push_back(s);
                if (bits_q.size() == FRAME_LEN) begin
                    for (int i = 0; i < DATA_W; i++) w[i] = bits_q[i];
`ifdef PARITY_EN
                    p = (^w) ^ bits_q[DATA_W];
`endif
                    done = 1;
                    bits_q.delete();
                end
            end
            if (done) begin
                if (!buf_full || rdy) begin
                    exp_q.push_back('{w: w, p: p});
                    dout_exp = w;
                    buf_full = 1;
                end else begin
                    ovr_exp = 1;
                end
            end else if (accept) begin
                buf_full = 0;
            end
        end
    endtask

    task automatic cycle(input bit se, input bit s, input bit rdy, input bit clr);
        ShiftEn = se;
        Sin     = s;
        Ready   = rdy;
        Clr     = clr;
        @(posedge Clk);
        model_edge(se, s, rdy, clr);
        #1;
        check("valid", Valid, buf_full);
        check("overrun", Overrun, ovr_exp);
        check("bitcnt", BitCnt, bits_q.size());
        check("dout_hold", Dout, dout_exp);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        #2;
        model_reset();
        check("rst_dout", Dout, 0);
        check("rst_valid", Valid, 0);
        check("rst_perr", ParityErr, 0);
        check("rst_overrun", Overrun, 0);
        check("rst_bitcnt", BitCnt, 0);
        @(negedge Clk);
        #1;
        nReset = 1'b1;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit par, input bit rdy);
        for (int i = 0; i < DATA_W; i++) cycle(1'b1, w[i], rdy, 1'b0);
`ifdef PARITY_EN
        cycle(1'b1, par, rdy, 1'b0);
`endif
    endtask

    initial begin
        nReset  = 1'b1;
        Clr     = 1'b0;
        ShiftEn = 1'b0;
        Sin     = 1'b0;
        Ready   = 1'b0;
        model_reset();
        #1;
        do_reset();

        // flush of a partial frame
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        send_word(8'hAA, ^8'hAA, 1'b0);
        check("flush_aa_dout", Dout, 8'hAA);
        check("flush_aa_ovr", Overrun, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // LSB-first assembly with a single-cycle Valid pulse
        send_word(8'hAA, ^8'hAA, 1'b1);
        check("aa_valid", Valid, 1);
        check("aa_bitcnt", BitCnt, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("aa_valid_fall", Valid, 0);

        // back-to-back with no bubbles
        send_word(8'h5A, ^8'h5A, 1'b1);
        send_word(8'hC3, ^8'hC3, 1'b1);
        check("b2b_dout", Dout, 8'hC3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // back-pressure: second word dropped, then accept, then flush
        send_word(8'h11, ^8'h11, 1'b0);
        send_word(8'h22, ^8'h22, 1'b0);
        check("bp_dout", Dout, 8'h11);
        check("bp_overrun", Overrun, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_valid_fall", Valid, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_clr_ovr", Overrun, 0);
        check("bp_clr_dout", Dout, 8'h11);

        // gapped input
        for (int i = 0; i < DATA_W; i++) begin
            cycle(1'b1, (8'hF0 >> i) & 1, 1'b1, 1'b0);
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
        end
`ifdef PARITY_EN
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
`endif
        check("gap_dout", Dout, 8'hF0);

`ifdef PARITY_EN
        send_word(8'h03, 1'b0, 1'b1);
        check("par_ok", ParityErr, 0);
        send_word(8'h03, 1'b1, 1'b1);
        check("par_err", ParityErr, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // reset mid-frame
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0,
                      $urandom_range(0, 149) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_deframer.md
# serial_deframer

- Serial-in, parallel-out receiver sitting directly downstream of the byte shift register.
- Consumes the shift register's serial output, LSB first, one bit per enabled clock, and reassembles complete words.
- Presents each complete word on a one-entry valid/ready output buffer to the next stage.
- Flags words lost to back-pressure; optionally checks an even-parity bit.

## Interface
- DATA_W, default 8, word width in bits (≥2).
- Clk  input  1  rising-edge clock; the single clock for all state.
- nReset  input  1  asynchronous, active-low reset.
- Clr  input  1  synchronous flush of the partial word, Valid and Overrun.
- ShiftEn  input  1  qualifies Sin; a bit is sampled only on edges where ShiftEn=1.
- Sin  input  1  serial data, LSB first; driven by the upstream Sout.
- Ready  input  1  downstream accepts Dout on an edge where Valid=Ready=1.
- Dout  output  DATA_W  assembled word held in the output buffer.
- Valid  output  1  output buffer holds an unaccepted word.
- ParityErr  output  1  parity result for the word on Dout; qualified by Valid.
- Overrun  output  1  sticky: a completed word was dropped.
- BitCnt  output  $clog2(DATA_W+2)  bits collected in the current frame.

## Operation
- Reset, nReset=0, asynchronous: Dout=0, Valid=0, ParityErr=0, Overrun=0, BitCnt=0, shift register 0, FSM=COLLECT.
- Collect FSM:
  - COLLECT: each sampled bit enters at the MSB of the partial register and shifts right, so the first bit ends at bit 0.
  - BitCnt increments on each sampled bit.
  - On the DATA_W-th bit: without PARITY_EN the word completes; with PARITY_EN go to PARITY.
  - PARITY: the next sampled bit is the parity bit. The word completes and ParityErr = XOR(data, parity bit) (even parity). Return to COLLECT.
- On word completion:
  - BitCnt returns to 0.
  - If the buffer is empty, or is being accepted on the same edge: load Dout/ParityErr and set Valid=1.
  - Otherwise: drop the new word, keep the buffer unchanged, set Overrun=1.
- Handshake:
  - On an edge with Valid=1 and Ready=1, the word is consumed and Valid falls next cycle, unless a word completes on that same edge.
  - If a word completes on that edge, Valid stays 1 and Dout updates.
  - Dout and ParityErr stay stable while Valid=1 and Ready=0.
- Clr=1:
  - Clears BitCnt, the partial word, the FSM (to COLLECT), Valid and Overrun.
  - Dout keeps its value.
  - Clr has priority over ShiftEn and Ready on the same edge.
- ShiftEn=0 freezes the collect side; gaps between bits are unlimited.

## Timing
- Valid rises on the edge that samples the final frame bit; it is visible the cycle after that bit was presented.
- Throughput: one word per DATA_W (or DATA_W+1) enabled cycles; zero bubbles when Ready is held high.
- Overrun sets on the edge of the dropped completion and is cleared only by Clr or reset.
- Reset asserted mid-frame or mid-handshake discards everything immediately; no partial word survives.

## Configuration
- PARITY_EN defined:
  - A frame is DATA_W+1 bits; the last bit is even parity.
  - ParityErr is live, and the PARITY state exists.
- PARITY_EN undefined:
  - A frame is DATA_W bits.
  - ParityErr is tied to 0, and no PARITY state is built.
- Port list is identical in both builds.

## Structure
- Shared package `deframer_pkg` holds:
  - the collect-state enum (COLLECT, PARITY);
  - the default word-width constant;
  - the frame-length constant derived from PARITY_EN.
- One sub-module, `deframer_outbuf`: the one-entry valid/ready holding register with overrun detection.
- The collect FSM, shift register and counter live in the top module.

## Test plan
- Reset/flush, default build: hold nReset=0, then release → all outputs 0. Then 3 bits with ShiftEn=1, Clr=1 → BitCnt=0, no Valid. Then 8 fresh bits 0,1,0,1,0,1,0,1 → Dout=8'hAA, Overrun=0.
- LSB-first assembly, default build: Ready=1; 8 bits 0,1,0,1,0,1,0,1 with ShiftEn=1 → Dout=8'hAA, Valid high for exactly one cycle after the 8th bit edge; BitCnt returns to 0.
- Back-to-back: Ready=1, 16 continuous bits for 8'h5A then 8'hC3 → two single-cycle Valid pulses eight cycles apart, no Overrun.
- Back-pressure/overrun: Ready=0, feed 8'h11 then 8'h22 → Dout stays 8'h11, Overrun=1 on the 16th bit edge. Ready=1 → 8'h11 accepted, Valid falls. Clr → Overrun=0.
- Gapped input: 8'hF0 bits with ShiftEn toggling 1,0 each cycle → Dout=8'hF0 after 16 cycles; BitCnt holds during gaps.
- PARITY_EN build: 8'h03 with parity bit 0 → ParityErr=0. 8'h03 with parity bit 1 → ParityErr=1. Each Valid one cycle after the 9th bit edge.
